// File: rtl/transpose_pkg.sv
// Shared types and default geometry for the transpose scheduler and its engine.
package transpose_pkg;

  localparam int unsigned TP_NUM_REQ    = 4;
  localparam int unsigned TP_NUM_PE     = 8;
  localparam int unsigned TP_DATA_WIDTH = 64;
  localparam int unsigned ROW_W         = TP_NUM_PE * TP_DATA_WIDTH;
  localparam int unsigned ID_W          = $clog2(TP_NUM_REQ);

  typedef enum logic [1:0] {
    StArb,
    StXfer,
    StGap
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdW-1:0]     id_o
);

  int idx;

  // Scan farthest-first so the candidate closest to ptr overwrites the rest.
  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    idx   = 0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      idx = (int'(ptr_i) + i) % int'(NUM_REQ);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        id_o       = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/transpose_sched.sv
// Round-robin front end sharing one ping-pong transpose engine between requesters,
// with a 2-deep owner tag FIFO steering engine output rows back to their source.
module transpose_sched
  import transpose_pkg::*;
#(
  parameter int unsigned NUM_REQ    = TP_NUM_REQ,
  parameter int unsigned NUM_PE     = TP_NUM_PE,
  parameter int unsigned DATA_WIDTH = TP_DATA_WIDTH,
  localparam int unsigned RowW      = NUM_PE * DATA_WIDTH,
  localparam int unsigned IdW       = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_val,
  output logic [NUM_REQ-1:0]      req_rdy,
  input  logic [NUM_REQ*RowW-1:0] req_data,
  output logic                    eng_val,
  output logic [RowW-1:0]         eng_data,
  input  logic                    eng_out_val,
  input  logic [RowW-1:0]         eng_out_data,
  output logic [NUM_REQ-1:0]      rsp_val,
  output logic [RowW-1:0]         rsp_data,
  output logic                    rsp_last,
  output logic [IdW-1:0]          grant_id,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned CntW     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(NUM_PE - 1);
  localparam logic [IdW-1:0]  LastId   = IdW'(NUM_REQ - 1);

  sched_state_e    state_q;
  logic [IdW-1:0]  grant_q, rr_ptr_q;
  logic [CntW-1:0] beat_cnt_q, out_cnt_q;
  logic [IdW-1:0]  tag_mem_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      count_q;
  logic            err_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IdW-1:0]     arb_id;
  logic               arb_any, accept, push, pop, fifo_empty, out_beat;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req_i(req_val),
    .ptr_i(rr_ptr_q),
    .gnt_o(arb_gnt),
    .id_o (arb_id)
  );

  assign arb_any    = |arb_gnt;
  assign fifo_empty = (count_q == 2'd0);
  assign accept     = (state_q == StXfer) && req_val[grant_q];
  assign push       = accept && (beat_cnt_q == LastBeat);
  assign out_beat   = eng_out_val && !fifo_empty;
  assign pop        = out_beat && (out_cnt_q == LastBeat);

  assign req_rdy  = (state_q == StXfer) ? (NUM_REQ'(1) << grant_q) : '0;
  assign eng_val  = accept;
  assign eng_data = req_data[int'(grant_q) * RowW +: RowW];
  assign rsp_val  = out_beat ? (NUM_REQ'(1) << tag_mem_q[rd_ptr_q]) : '0;
  assign rsp_data = eng_out_data;
  assign rsp_last = eng_out_val && (out_cnt_q == LastBeat);
  assign grant_id = grant_q;
  assign busy     = (state_q != StArb) || !fifo_empty;
  assign err      = err_q;

  // A full tag FIFO means both banks hold unread tiles, so no new grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StArb;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StArb: begin
          if (arb_any && (count_q <= 2'd1)) begin
            grant_q    <= arb_id;
            beat_cnt_q <= '0;
            state_q    <= StXfer;
          end
        end
        StXfer: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == LastBeat) begin
              rr_ptr_q <= (grant_q == LastId) ? '0 : grant_q + 1'b1;
              state_q  <= StGap;
            end
          end
        end
        StGap:   state_q <= StArb;
        default: state_q <= StArb;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_mem_q[0] <= '0;
      tag_mem_q[1] <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      out_cnt_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      if (push) begin
        tag_mem_q[wr_ptr_q] <= grant_q;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      if (push && !pop) count_q <= count_q + 2'd1;
      else if (pop && !push) count_q <= count_q - 2'd1;
      if (out_beat) out_cnt_q <= (out_cnt_q == LastBeat) ? '0 : out_cnt_q + 1'b1;
      if (eng_out_val && fifo_empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_transpose_sched.sv
// Directed-plus-random bench for transpose_sched against a tile-level reference model.
module tb_transpose_sched;

  localparam int NR  = 4;
  localparam int NPE = 8;
  localparam int DW  = 64;
  localparam int RW  = NPE * DW;
  localparam int IW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_val;
  logic [NR-1:0]   req_rdy;
  logic [NR*RW-1:0] req_data;
  logic            eng_val;
  logic [RW-1:0]   eng_data;
  logic            eng_out_val;
  logic [RW-1:0]   eng_out_data;
  logic [NR-1:0]   rsp_val;
  logic [RW-1:0]   rsp_data;
  logic            rsp_last;
  logic [IW-1:0]   grant_id;
  logic            busy;
  logic            err;

  transpose_sched dut (
    .clk         (clk),
    .rst         (rst),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_data    (req_data),
    .eng_val     (eng_val),
    .eng_data    (eng_data),
    .eng_out_val (eng_out_val),
    .eng_out_data(eng_out_data),
    .rsp_val     (rsp_val),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .grant_id    (grant_id),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int obs_rdy1, obs_ev, obs_last, obs_rsp1;

  // Reference model: who owns the input port, how many of its beats have landed,
  // the pending gap cycle, the round-robin start point, and tiles awaiting readout.
  int m_owner, m_beats, m_ptr, m_last, m_outcnt;
  bit m_gap, m_err;
  int m_tags[$];

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_beats  = 0;
    m_ptr    = 0;
    m_last   = 0;
    m_outcnt = 0;
    m_gap    = 1'b0;
    m_err    = 1'b0;
    m_tags.delete();
  endtask

  task automatic model_step();
    int sz;
    int dmy;
    bit found;
    sz = m_tags.size();
    if (eng_out_val) begin
      if (sz == 0) m_err = 1'b1;
      else if (m_outcnt == NPE - 1) begin
        m_outcnt = 0;
        dmy = m_tags.pop_front();
      end else m_outcnt++;
    end
    if (m_gap) m_gap = 1'b0;
    else if (m_owner >= 0) begin
      if (req_val[m_owner]) begin
        m_beats++;
        if (m_beats == NPE) begin
          m_tags.push_back(m_owner);
          m_ptr   = (m_owner + 1) % NR;
          m_owner = -1;
          m_gap   = 1'b1;
        end
      end
    end else if (req_val != '0 && sz <= 1) begin
      found = 1'b0;
      for (int k = 0; k < NR; k++) begin
        if (!found && req_val[(m_ptr + k) % NR]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % NR;
        end
      end
      m_beats = 0;
      m_last  = m_owner;
    end
  endtask

  function automatic logic [NR-1:0] owner_mask();
    logic [NR-1:0] m;
    m = '0;
    if (m_owner >= 0) m[m_owner] = 1'b1;
    return m;
  endfunction

  // mode: 0 engine silent, 1 random output when a tile is ready, 2 output whenever
  // a tile is ready, 3 force one output beat regardless.
  task automatic cycle(input logic [NR-1:0] rv, input int mode);
    logic [NR-1:0] exp_rdy, exp_rspv;
    logic          exp_ev, exp_last, exp_busy;
    req_val = rv;
    for (int k = 0; k < NR * RW / 32; k++) req_data[k*32 +: 32] = $urandom;
    for (int k = 0; k < RW / 32; k++) eng_out_data[k*32 +: 32] = $urandom;
    case (mode)
      1:       eng_out_val = (m_tags.size() > 0) && ($urandom_range(0, 1) == 1);
      2:       eng_out_val = (m_tags.size() > 0);
      3:       eng_out_val = 1'b1;
      default: eng_out_val = 1'b0;
    endcase
    @(negedge clk);
    exp_rdy = owner_mask();
    exp_ev  = 1'b0;
    if (m_owner >= 0) exp_ev = req_val[m_owner];
    exp_rspv = '0;
    if (eng_out_val && m_tags.size() > 0) exp_rspv[m_tags[0]] = 1'b1;
    exp_last = eng_out_val && (m_outcnt == NPE - 1);
    exp_busy = (m_owner >= 0) || m_gap || (m_tags.size() > 0);
    chk("req_rdy", req_rdy, exp_rdy);
    chk("eng_val", eng_val, exp_ev);
    if (exp_ev) chk("eng_data", eng_data, req_data[m_owner*RW +: RW]);
    chk("rsp_val", rsp_val, exp_rspv);
    chk("rsp_last", rsp_last, exp_last);
    chk("rsp_data", rsp_data, eng_out_data);
    chk("grant_id", grant_id, m_last[IW-1:0]);
    chk("busy", busy, exp_busy);
    chk("err", err, m_err);
    obs_rdy1 += int'(req_rdy[1]);
    obs_ev   += int'(eng_val);
    obs_last += int'(rsp_last);
    obs_rsp1 += int'(rsp_val == 4'b0010);
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 80; n++) begin
      if (m_owner < 0 && !m_gap && m_tags.size() == 0) break;
      cycle(owner_mask(), 2);
    end
    chk("drain_idle", busy, 1'b0);
  endtask

  task automatic async_reset();
    eng_out_val = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_req_rdy", req_rdy, '0);
    chk("arst_eng_val", eng_val, 1'b0);
    chk("arst_rsp_val", rsp_val, '0);
    chk("arst_rsp_last", rsp_last, 1'b0);
    chk("arst_grant_id", grant_id, '0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_err", err, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_val = '0;
    req_data = '0;
    eng_out_val = 1'b0;
    eng_out_data = '0;
    model_reset();
    #6;
    cycle('0, 0);
    cycle('0, 0);
    rst = 1'b0;

    // All requesters valid with the engine held off: two tiles then stall on a full FIFO.
    for (int n = 0; n < 40; n++) cycle(4'b1111, 0);
    chk("stall_grant", grant_id, 2'd1);
    chk("stall_rdy", req_rdy, 4'b0000);
    chk("stall_busy", busy, 1'b1);
    for (int n = 0; n < 40; n++) cycle(4'b1111, 2);
    drain();

    // Lone requester 1: 8 ready cycles, then a returned tile routed back to it.
    obs_rdy1 = 0;
    for (int n = 0; n < 10; n++) cycle(4'b0010, 0);
    chk("single_rdy_cycles", 32'(obs_rdy1), 32'd8);
    for (int n = 0; n < 10; n++) cycle('0, 0);
    obs_rsp1 = 0;
    obs_last = 0;
    for (int n = 0; n < 10; n++) cycle('0, 2);
    chk("single_rsp_rows", 32'(obs_rsp1), 32'd8);
    chk("single_rsp_last", 32'(obs_last), 32'd1);

    // Requester 2 pauses for three cycles after its fourth beat.
    obs_ev = 0;
    for (int j = 0; j < 14; j++)
      cycle((j >= 5 && j <= 7) || j >= 12 ? 4'b0000 : 4'b0100, 0);
    chk("gap_eng_beats", 32'(obs_ev), 32'd8);
    drain();

    // Random traffic with overlapping drain and fill.
    for (int n = 0; n < 250; n++) begin
      logic [NR-1:0] rv;
      for (int b = 0; b < NR; b++) rv[b] = ($urandom_range(0, 3) != 0);
      cycle(rv, 1);
    end
    drain();

    // Engine output with nothing in flight.
    cycle('0, 3);
    for (int n = 0; n < 3; n++) cycle('0, 0);
    chk("err_sticky", err, 1'b1);

    // Reset in the middle of a tile, then a fresh round starting at requester 0.
    for (int n = 0; n < 6; n++) cycle(4'b1111, 0);
    async_reset();
    cycle(4'b1111, 0);
    cycle(4'b1111, 0);
    chk("post_rst_grant", grant_id, 2'd0);
    chk("post_rst_rdy", req_rdy, 4'b0001);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
